// File: rtl/mul64_unsigned.sv
// Unsigned W x W tree multiplier: AND-gated partial products, 3:2 carry-save
// reduction tree, Kogge-Stone final adder, plus a registered copy of the product.
`default_nettype none

module mul64_unsigned #(
  parameter int W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic [2*W-1:0]   o,
  output logic [2*W-1:0]   o_q
);

  localparam int P = 2 * W;

  // Rows remaining after a given number of 3:2 reduction levels.
  function automatic int rows_at(input int lvl);
    int n;
    n = W;
    for (int k = 0; k < lvl; k++) n = 2 * (n / 3) + (n % 3);
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int c;
    n = W;
    c = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      c++;
    end
    return c;
  endfunction

  localparam int LV = num_levels();
  localparam int PL = $clog2(P);

  logic [P-1:0] t [0:LV][0:W-1];

  for (genvar i = 0; i < W; i++) begin : g_pp
    assign t[0][i] = {{W{1'b0}}, x & {W{y[i]}}} << i;
  end

  // Each level compresses groups of three rows into a sum row and a shifted
  // carry row; leftover rows pass straight through to the next level.
  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int N  = rows_at(l);
    localparam int NN = rows_at(l + 1);
    localparam int G  = N / 3;
    for (genvar j = 0; j < W; j++) begin : g_row
      if (j < G) begin : g_csa
        logic [P-1:0] a, b, c;
        assign a = t[l][3*j];
        assign b = t[l][3*j+1];
        assign c = t[l][3*j+2];
        assign t[l+1][2*j]   = a ^ b ^ c;
        assign t[l+1][2*j+1] = ((a & b) | (a & c) | (b & c)) << 1;
      end else if (j >= 3*G && j < N) begin : g_pass
        assign t[l+1][2*G + (j - 3*G)] = t[l][j];
      end
      if (j >= NN) begin : g_zero
        assign t[l+1][j] = '0;
      end
    end
  end

  // Kogge-Stone generate/propagate prefix tree over the two final rows.
  logic [P-1:0] g [0:PL];
  logic [P-1:0] p [0:PL];
  logic [P-1:0] hs;

  assign hs   = t[LV][0] ^ t[LV][1];
  assign g[0] = t[LV][0] & t[LV][1];
  assign p[0] = hs;

  for (genvar k = 0; k < PL; k++) begin : g_pfx
    localparam int D = 1 << k;
    assign g[k+1] = g[k] | (p[k] & (g[k] << D));
    assign p[k+1] = p[k] & ((p[k] << D) | {{(P-D){1'b0}}, {D{1'b1}}});
  end

  // Carry out of the top bit is dropped: the product always fits in 2*W bits.
  assign o = hs ^ {g[PL][P-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_q <= '0;
    else     o_q <= o;
  end

endmodule

`default_nettype wire

// File: tb/tb_mul64_unsigned.sv
// Self-checking bench for mul64_unsigned: directed, random and registered-path checks.
`default_nettype none

module tb_mul64_unsigned;

  logic         clk;
  logic         rst;
  logic [63:0]  x;
  logic [63:0]  y;
  logic [127:0] o;
  logic [127:0] o_q;

  int checks = 0;
  int errors = 0;

  mul64_unsigned #(.W(64)) dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y),
    .o   (o),
    .o_q (o_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] wa, wb;
    wa = {64'd0, a};
    wb = {64'd0, b};
    return wa * wb;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic comb(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [127:0] exp);
    x = a;
    y = b;
    #10;
    check(tag, o, exp);
    check({tag, "_ref"}, o, ref_mul(a, b));
  endtask

  initial begin
    logic [63:0] ra, rb;
    rst = 1'b1;
    x   = '0;
    y   = '0;
    #3;
    check("reset_oq", o_q, 128'h0);

    comb("zero",     64'h0, 64'h0, 128'h0);
    comb("max_x1",   64'hFFFFFFFFFFFFFFFF, 64'h1, 128'h0000000000000000FFFFFFFFFFFFFFFF);
    comb("max_max",  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
         128'hFFFFFFFFFFFFFFFE0000000000000001);
    comb("msb_x2",   64'h8000000000000000, 64'h2, 128'h00000000000000010000000000000000);
    comb("fffe_x2",  64'hFFFFFFFFFFFFFFFE, 64'h2, 128'h0000000000000001FFFFFFFFFFFFFFFC);
    comb("p1",       64'h1,  64'h1,  128'h1);
    comb("p2",       64'h2,  64'h2,  128'h4);
    comb("p4",       64'h4,  64'h4,  128'h10);
    comb("p8",       64'h8,  64'h8,  128'h40);
    comb("p16",      64'h10, 64'h10, 128'h100);
    comb("pat55",    64'h5555555555555555, 64'h2, 128'h0000000000000000AAAAAAAAAAAAAAAA);
    comb("patAA",    64'hAAAAAAAAAAAAAAAA, 64'h2, 128'h00000000000000015555555555555554);
    comb("bit127",   64'h8000000000000000, 64'h8000000000000000,
         128'h40000000000000000000000000000000);
    comb("zero_y",   64'h123456789ABCDEF0, 64'h0, 128'h0);
    check("reset_hold_oq", o_q, 128'h0);

    for (int i = 0; i < 88; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      x  = ra;
      y  = rb;
      #10;
      check("random", o, ref_mul(ra, rb));
    end

    // Registered path: release reset between edges, then capture 3*5.
    @(negedge clk);
    rst = 1'b0;
    x   = 64'd3;
    y   = 64'd5;
    @(posedge clk);
    #1;
    check("oq_capture", o_q, 128'hF);
    check("o_after_capture", o, 128'hF);
    #2;
    rst = 1'b1;
    #1;
    check("oq_async_reset", o_q, 128'h0);
    check("o_during_reset", o, 128'hF);
    @(posedge clk);
    #1;
    check("oq_reset_held", o_q, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("oq_recapture", o_q, 128'hF);

    // Capture follows operand changes with one cycle of latency.
    @(negedge clk);
    x = 64'hFFFFFFFFFFFFFFFF;
    y = 64'hFFFFFFFFFFFFFFFF;
    #1;
    check("oq_latency_old", o_q, 128'hF);
    @(posedge clk);
    #1;
    check("oq_latency_new", o_q, 128'hFFFFFFFFFFFFFFFE0000000000000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
